// File: rtl/reg_file.sv
// Two-read/one-write register file with same-cycle write forwarding and a
// per-register busy scoreboard for outstanding loads. Register 0 reads as zero.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  set_busy,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  wr_en;
  logic                  set_en;

  assign wr_en  = we && (wa != '0);
  assign set_en = set_busy && (busy_addr != '0);

  // A retiring write clears busy, but a load issued on the same edge re-arms it
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wa] = 1'b0;
    end
    if (set_en) begin
      busy_d[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wa] <= wd;
      end
      busy_q <= busy_d;
    end
  end

  // Forwarding and stall-release both key off a write retiring this cycle
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (!reset) begin
      if (ra1 != '0) begin
        rd1   = (wr_en && (wa == ra1)) ? wd : regs_q[ra1];
        busy1 = busy_q[ra1] && !(we && (wa == ra1));
      end
      if (ra2 != '0) begin
        rd2   = (wr_en && (wa == ra2)) ? wd : regs_q[ra2];
        busy2 = busy_q[ra2] && !(we && (wa == ra2));
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read-back, r0, forwarding,
// scoreboard set/clear, set-vs-write priority and asynchronous mid-cycle reset.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        set_busy;
  logic [4:0]  busy_addr;
  logic        busy1;
  logic        busy2;
  logic        sel;
  logic [31:0] mux_y;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .set_busy (set_busy),
    .busy_addr(busy_addr),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  // Downstream operand mux: sel=1 picks port 2 (B), sel=0 picks port 1 (A)
  assign mux_y = sel ? rd2 : rd1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle inputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    we        = 1'b1;
    wa        = 5'd12;
    wd        = 32'hDEADBEEF;
    set_busy  = 1'b1;
    busy_addr = 5'd12;
    ra1       = '0;
    ra2       = '0;
    sel       = 1'b0;

    // Reset with arbitrary inputs: everything reads zero, no forwarding
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      wa  = 5'(i);
      #3;
      check($sformatf("rst_rd1[%0d]", i), rd1, 32'h0);
      check($sformatf("rst_rd2[%0d]", 31 - i), rd2, 32'h0);
      check("rst_busy1", 32'(busy1), 32'h0);
      check("rst_busy2", 32'(busy2), 32'h0);
    end
    tick();
    @(negedge clk);
    reset    = 1'b0;
    we       = 1'b0;
    set_busy = 1'b0;
    ra1      = 5'd12;
    #1;
    check("post_rst_r12", rd1, 32'h0);
    check("post_rst_busy12", 32'(busy1), 32'h0);

    // Write/read-back r5, r6
    we = 1'b1; wa = 5'd5; wd = 32'hAAAAAAAA;
    tick();
    wa = 5'd6; wd = 32'h55555555;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd6;
    #1;
    check("rb_r5", rd1, 32'hAAAAAAAA);
    check("rb_r6", rd2, 32'h55555555);
    sel = 1'b1; #1;
    check("mux_sel1", mux_y, 32'h55555555);
    sel = 1'b0; #1;
    check("mux_sel0", mux_y, 32'hAAAAAAAA);
    ra2 = 5'd5; #1;
    check("same_addr", rd2, 32'hAAAAAAAA);

    // r0 is hardwired zero, also when forwarding would apply
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("r0_fwd", rd1, 32'h0);
    tick();
    we = 1'b0; #1;
    check("r0_store", rd1, 32'h0);

    // Same-cycle forwarding on port 2
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra2 = 5'd7; ra1 = 5'd6;
    #1;
    check("fwd_rd2", rd2, 32'hA5A5A5A5);
    check("fwd_rd1_other", rd1, 32'h55555555);
    tick();
    we = 1'b0; wd = 32'h0; #1;
    check("fwd_stored", rd2, 32'hA5A5A5A5);

    // Scoreboard: set, then clear by retiring write
    set_busy = 1'b1; busy_addr = 5'd9; ra1 = 5'd9;
    #1;
    check("busy_pre_edge", 32'(busy1), 32'h0);
    tick();
    set_busy = 1'b0; #1;
    check("busy_set", 32'(busy1), 32'h1);
    we = 1'b1; wa = 5'd9; wd = 32'hDDDDDDDD; #1;
    check("busy_release", 32'(busy1), 32'h0);
    check("busy_fwd_rd1", rd1, 32'hDDDDDDDD);
    tick();
    we = 1'b0; #1;
    check("busy_cleared", 32'(busy1), 32'h0);
    check("r9_stored", rd1, 32'hDDDDDDDD);

    // busy on r0 is never set
    set_busy = 1'b1; busy_addr = 5'd0; ra2 = 5'd0;
    tick();
    set_busy = 1'b0; #1;
    check("busy_r0", 32'(busy2), 32'h0);

    // Simultaneous set_busy and write on r3: data written, busy wins
    set_busy = 1'b1; busy_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33333333;
    tick();
    set_busy = 1'b0; we = 1'b0; ra1 = 5'd3; ra2 = 5'd3; #1;
    check("setwr_data", rd1, 32'h33333333);
    check("setwr_busy1", 32'(busy1), 32'h1);
    check("setwr_busy2", 32'(busy2), 32'h1);

    // Mid-operation asynchronous reset with r4 loaded and busy
    set_busy = 1'b1; busy_addr = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h12345678;
    tick();
    set_busy = 1'b0; we = 1'b0; ra1 = 5'd4; ra2 = 5'd5; #1;
    check("r4_loaded", rd1, 32'h12345678);
    check("r4_busy", 32'(busy1), 32'h1);
    #1;
    reset = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'hCAFEF00D;
    #1;
    check("async_rd1", rd1, 32'h0);
    check("async_busy1", 32'(busy1), 32'h0);
    tick();
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    #1;
    check("rst_write_dropped", rd1, 32'h0);
    check("rst_busy_dropped", 32'(busy1), 32'h0);
    check("rst_r5_cleared", rd2, 32'h0);
    tick();
    check("rst_r4_after_edge", rd1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read/one-write register file with an operand scoreboard, sitting directly upstream of the 32-bit 2:1 operand `MUX`. Read port 1 drives the mux's A input. Read port 2 drives its B input, or the datapath substitutes the immediate via `sel`. Writes retire synchronously; reads are combinational with same-cycle write forwarding. Per-register busy bits flag operands whose producing load is still outstanding, so the hazard unit can stall.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of the read/write data.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- we  in  1  write enable, sampled at the rising edge of clk.
- wa  in  ADDR_WIDTH  write address.
- wd  in  DATA_WIDTH  write data.
- ra1  in  ADDR_WIDTH  read address, port 1 (feeds mux A).
- ra2  in  ADDR_WIDTH  read address, port 2 (feeds mux B).
- rd1  out  DATA_WIDTH  read data, port 1.
- rd2  out  DATA_WIDTH  read data, port 2.
- set_busy  in  1  marks register busy_addr as having a pending write.
- busy_addr  in  ADDR_WIDTH  register to mark busy.
- busy1  out  1  ra1 has a pending write.
- busy2  out  1  ra2 has a pending write.

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, plus one busy bit per register.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - rd1/rd2 read 0 at address 0.
  - The busy bit for register 0 is never set; busy1/busy2 read 0 at address 0.
- Write: at the rising edge with we=1 and wa≠0, reg[wa] ← wd, and busy[wa] is cleared.
- Read, for port n:
  - If we=1, wa=ran and ran≠0, then rdn = wd (forwarding).
  - Otherwise rdn = reg[ran].
  - Both ports are independent; ra1=ra2 is legal and yields identical outputs.
- Scoreboard:
  - At the rising edge with set_busy=1 and busy_addr≠0, busy[busy_addr] ← 1.
  - If set_busy and we target the same nonzero address in one edge, set wins: data is written and busy stays 1, because a new load has been issued.
- Busy outputs, for port n:
  - busyn = busy[ran] & ~(we & (wa==ran)).
  - A retiring write therefore releases the stall in the same cycle its data is forwarded.
- Reset (asynchronous):
  - All registers go to 0 and all busy bits go to 0 immediately on assertion, independent of clk.
  - While reset=1, writes and set_busy are ignored, forwarding is suppressed, rd1=rd2=0 and busy1=busy2=0.
  - Reset asserted mid-operation discards any write presented in that cycle.

## Timing
- Read latency: 0 cycles (combinational from ra1/ra2, we, wa and wd).
- Write latency: 1 edge; the value is visible from storage in the cycle after the edge, and via forwarding in the same cycle.
- Busy set: visible the cycle after the set_busy edge. Busy clear: visible combinationally during the write cycle, and from storage afterwards.
- Reset deassertion: the first active edge is the first rising clk edge with reset=0; no synchronizer is inside the block.
- Output reset values: rd1=0, rd2=0, busy1=0, busy2=0.
- No internal multicycle paths.

## Test plan
- Reset then read: assert reset with arbitrary inputs; read all 32 addresses -> every rd1/rd2 = 32'h00000000, busy1=busy2=0.
- Write/read-back: write 32'hAAAAAAAA to r5 and 32'h55555555 to r6; ra1=5, ra2=6 -> rd1=AAAAAAAA, rd2=55555555; drive mux sel=1/0 downstream -> Y matches the selected operand.
- r0 and forwarding:
  - Write 32'hFFFFFFFF to r0, then read ra1=0 -> 0.
  - Same cycle, we=1, wa=7, wd=32'hA5A5A5A5, ra2=7 -> rd2=A5A5A5A5 before the edge.
- Scoreboard:
  - set_busy r9 -> next cycle, ra1=9 gives busy1=1.
  - Write r9 = 32'hDDDDDDDD -> busy1=0 during the write cycle and rd1=DDDDDDDD; busy1 stays 0 afterwards.
- Simultaneous set and write: set_busy and we both on r3 at one edge -> r3 holds wd, busy[3]=1 afterwards.
- Mid-operation reset: r4=32'h12345678 with busy[4]=1; pulse reset between edges (asynchronously) -> rd1(ra1=4)=0 and busy1=0 immediately; a write presented during reset is not stored.
